// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M/RV64M multiply/divide unit:
// funct3 op encoding, controller states and an op-class helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op inside {DIV, DIVU, REM, REMU});
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage (master) and muldiv_unit (slave).
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output in_valid_i, funct3_i, rs1_i, rs2_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, tag_o
    );

    modport slave (
        input  in_valid_i, funct3_i, rs1_i, rs2_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, tag_o
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Magnitude datapath: shift-add multiply / restoring divide over a 2*XLEN
// register whose upper half is the partial product or running remainder.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  muldiv_op_e      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            fast_o,
    output logic [XLEN-1:0] result_o
);
    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_op_e      op_q;
    logic [W2-1:0]   prod_q;
    logic [XLEN-1:0] b_q;
    logic            neg_hi_q, neg_lo_q;

    logic            neg_a_s, neg_b_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s;
    logic [XLEN:0]   add_s, shl_s, diff_s;
    logic [W2-1:0]   mul_next_s, div_next_s, prod_fix_s;

    // Operand signedness, magnitudes and fast-path detection for the incoming op
    always_comb begin
        neg_a_s    = (op_i inside {MULH, MULHSU, DIV, REM}) && rs1_i[XLEN-1];
        neg_b_s    = (op_i inside {MULH, DIV, REM}) && rs2_i[XLEN-1];
        abs_a_s    = neg_a_s ? -rs1_i : rs1_i;
        abs_b_s    = neg_b_s ? -rs2_i : rs2_i;
        div_zero_s = (rs2_i == {XLEN{1'b0}});
        div_ovf_s  = (op_i inside {DIV, REM}) && (rs1_i == MIN_NEG) && (rs2_i == {XLEN{1'b1}});
        fast_o     = is_div(op_i) && (div_zero_s || div_ovf_s);
    end

    // One radix-2 multiply step and one restoring-divide step
    always_comb begin
        add_s = {1'b0, prod_q[W2-1:XLEN]} + {1'b0, b_q};
        if (prod_q[0]) begin
            mul_next_s = {add_s, prod_q[XLEN-1:1]};
        end else begin
            mul_next_s = {1'b0, prod_q[W2-1:1]};
        end
        shl_s  = {prod_q[W2-1:XLEN], prod_q[XLEN-1]};
        diff_s = shl_s - {1'b0, b_q};
        // A clear top bit means the trial subtraction did not borrow.
        if (!diff_s[XLEN]) begin
            div_next_s = {diff_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {shl_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result half selection
    always_comb begin
        if (is_div(op_q)) begin
            prod_fix_s = {(neg_hi_q ? -prod_q[W2-1:XLEN] : prod_q[W2-1:XLEN]),
                          (neg_lo_q ? -prod_q[XLEN-1:0]  : prod_q[XLEN-1:0])};
        end else begin
            prod_fix_s = neg_lo_q ? -prod_q : prod_q;
        end
        case (op_q)
            MUL, DIV, DIVU: result_o = prod_fix_s[XLEN-1:0];
            default:        result_o = prod_fix_s[W2-1:XLEN];
        endcase
    end

    // Operand latch, iteration and in-place sign fix
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= MUL;
            prod_q   <= {W2{1'b0}};
            b_q      <= {XLEN{1'b0}};
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
        end else if (start_i) begin
            op_q <= op_i;
            b_q  <= abs_b_s;
            if (fast_o) begin
                prod_q   <= {(div_zero_s ? rs1_i : {XLEN{1'b0}}),
                             (div_zero_s ? {XLEN{1'b1}} : rs1_i)};
                neg_hi_q <= 1'b0;
                neg_lo_q <= 1'b0;
            end else begin
                prod_q   <= {{XLEN{1'b0}}, abs_a_s};
                neg_lo_q <= neg_a_s ^ neg_b_s;
                neg_hi_q <= is_div(op_i) ? neg_a_s : (neg_a_s ^ neg_b_s);
            end
        end else if (step_i) begin
            prod_q <= is_div(op_q) ? div_next_s : mul_next_s;
        end else if (fix_i) begin
            prod_q <= prod_fix_s;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: handshake FSM, tag register and registered
// outputs around muldiv_datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic     clk_i,
    input logic     rst_i,
    input logic     flush_i,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q, out_valid_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;

    logic             start_s, step_s, fix_s, fast_s;
    logic [XLEN-1:0]  dp_result_s;

    // Datapath control; a flush suppresses every datapath update
    always_comb begin
        start_s = 1'b0;
        step_s  = 1'b0;
        fix_s   = 1'b0;
        if (!flush_i) begin
            start_s = (state_q == IDLE) && in_ready_q && bus.in_valid_i;
            step_s  = (state_q == ITER);
            fix_s   = (state_q == FIX);
        end else begin
            start_s = 1'b0;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_s),
        .step_i   (step_s),
        .fix_i    (fix_s),
        .op_i     (muldiv_op_e'(bus.funct3_i)),
        .rs1_i    (bus.rs1_i),
        .rs2_i    (bus.rs2_i),
        .fast_o   (fast_s),
        .result_o (dp_result_s)
    );

    // Controller FSM with registered handshake, result and tag outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            tag_q       <= {TAG_W{1'b0}};
        end else if (flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        tag_q      <= bus.tag_i;
                        in_ready_q <= 1'b0;
                        cnt_q      <= {CNT_W{1'b0}};
                        // Fast-path results are preloaded; FIX only publishes them.
                        state_q    <= fast_s ? FIX : ITER;
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q    <= dp_result_s;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.tag_o       = tag_q;

endmodule
